// File: rtl/cache_control_nway.sv
// -----------------------------------------------------------------------------
// cache_control_nway
//
// Control FSM for a WAYS-way set-associative, write-back, write-allocate cache.
// It sits between the cache datapath (tag/valid/dirty/data arrays and PLRU
// array) and the cacheline adaptor. Victims are chosen from the lowest-index
// invalid way, or from the tree pseudo-LRU if the set is full. A full-cache
// flush walks every (set, way) pair and writes back each valid dirty line.
//
// Parameters
//   WAYS      ways per set (power of 2, 2..8)
//   SET_BITS  set-index width; the flush walk covers 2**SET_BITS sets
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   mem_read, mem_write, mem_resp CPU request (held) / one-cycle completion
//   flush_req, flush_done         flush request (level) / one-cycle done pulse
//   valid_i, dirty_i, cmp_i       per-way status of the addressed set
//   plru_i                        PLRU tree of the addressed set (bit 0 = root)
//   plru_load, plru_o             PLRU array write enable / new tree
//   valid_*, dirty_*, tag_load    per-way array write enables and data
//   data_we_cpu, data_we_fill     CPU byte write / full-line fill per way
//   dimux_sel                     data-in source: 0 = CPU, 1 = memory line
//   domux_sel                     way driving the data output
//   addrmux_sel                   pmem address: 0 = CPU, 1 = {tag[way], set}
//   set_ovr, flush_set            datapath set index override during a flush
//   pmem_read, pmem_write         memory requests (held until pmem_resp)
//   pmem_resp                     cacheline adaptor done pulse
// -----------------------------------------------------------------------------
module cache_control_nway #(
  parameter  int WAYS     = 4,
  parameter  int SET_BITS = 3,
  localparam int WB       = $clog2(WAYS)
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                mem_read,
  input  logic                mem_write,
  output logic                mem_resp,

  input  logic                flush_req,
  output logic                flush_done,

  input  logic [WAYS-1:0]     valid_i,
  input  logic [WAYS-1:0]     dirty_i,
  input  logic [WAYS-1:0]     cmp_i,
  input  logic [WAYS-2:0]     plru_i,

  output logic                plru_load,
  output logic [WAYS-2:0]     plru_o,
  output logic [WAYS-1:0]     valid_load,
  output logic [WAYS-1:0]     valid_o,
  output logic [WAYS-1:0]     dirty_load,
  output logic [WAYS-1:0]     dirty_o,
  output logic [WAYS-1:0]     tag_load,
  output logic [WAYS-1:0]     data_we_cpu,
  output logic [WAYS-1:0]     data_we_fill,

  output logic                dimux_sel,
  output logic [WB-1:0]       domux_sel,
  output logic [1:0]          addrmux_sel,
  output logic                set_ovr,
  output logic [SET_BITS-1:0] flush_set,

  output logic                pmem_read,
  output logic                pmem_write,
  input  logic                pmem_resp
);

  typedef enum logic [2:0] {
    HIT_CHECK,
    WRITE_BACK,
    READ_BACK,
    FLUSH_SCAN,
    FLUSH_WB,
    FLUSH_DONE
  } state_t;

  localparam logic [WB-1:0] LAST_WAY = WB'(WAYS - 1);

  state_t          state, state_nxt;
  logic [WB-1:0]   victim;
  logic [WB-1:0]   victim_choice;
  logic            victim_ld;
  logic [WB-1:0]   flush_way;
  logic            flush_adv;
  logic            flush_clr;
  logic            flush_last;

  logic [WAYS-1:0] hit;
  logic            hit_any;
  logic [WB-1:0]   hit_way;
  logic            inv_any;
  logic [WB-1:0]   inv_way;
  logic            req;

  logic [WAYS-1:0] hit_oh;
  logic [WAYS-1:0] victim_oh;
  logic [WAYS-1:0] flush_oh;

  // ---------------------------------------------------------------------------
  // PLRU helpers. Node n has children 2n+1 (lower ways) and 2n+2 (upper ways).
  // Bits are read and written through shifts so the node index can be a plain
  // int without width mismatches against the tree vector.
  // ---------------------------------------------------------------------------
  function automatic logic [WB-1:0] plru_victim(input logic [WAYS-2:0] tree);
    logic [WB-1:0]   way;
    logic [WAYS-2:0] sh;
    int              node;
    way  = '0;
    node = 0;
    for (int l = 0; l < WB; l++) begin
      sh   = tree >> node;
      // A 0 bit selects the lower-index subtree; the way index is built MSB first.
      way  = WB'({way, sh[0]});
      node = 2 * node + 1 + int'(sh[0]);
    end
    return way;
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] tree,
                                                 input logic [WB-1:0]   way);
    logic [WAYS-2:0] t;
    logic [WAYS-2:0] m;
    logic [WB-1:0]   ws;
    int              node;
    t    = tree;
    node = 0;
    for (int l = 0; l < WB; l++) begin
      ws = way >> (WB - 1 - l);
      m  = (WAYS-1)'(1) << node;
      // Point each node on the path away from the touched way.
      if (ws[0]) t = t & ~m;
      else       t = t | m;
      node = 2 * node + 1 + int'(ws[0]);
    end
    return t;
  endfunction

  // ---------------------------------------------------------------------------
  // Set status decode
  // ---------------------------------------------------------------------------
  assign hit     = valid_i & cmp_i;
  assign hit_any = |hit;
  assign inv_any = ~&valid_i;
  assign req     = mem_read | mem_write;

  // NOTE: every variable written in an always_comb gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      // Descending scan so the lowest index is the one that sticks.
      if (hit[w])      hit_way = WB'(w);
      if (!valid_i[w]) inv_way = WB'(w);
    end
  end

  assign victim_choice = inv_any ? inv_way : plru_victim(plru_i);

  assign hit_oh    = WAYS'(1) << hit_way;
  assign victim_oh = WAYS'(1) << victim;
  assign flush_oh  = WAYS'(1) << flush_way;

  assign flush_last = (flush_way == LAST_WAY) && (flush_set == '1);

  // ---------------------------------------------------------------------------
  // State, victim and flush walk registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HIT_CHECK;
      victim    <= '0;
      flush_set <= '0;
      flush_way <= '0;
    end else begin
      state <= state_nxt;
      if (victim_ld) victim <= victim_choice;
      if (flush_clr) begin
        flush_set <= '0;
        flush_way <= '0;
      end else if (flush_adv) begin
        flush_way <= flush_way + 1'b1;
        if (flush_way == LAST_WAY) flush_set <= flush_set + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    victim_ld    = 1'b0;
    flush_adv    = 1'b0;
    flush_clr    = 1'b0;

    mem_resp     = 1'b0;
    flush_done   = 1'b0;
    plru_load    = 1'b0;
    plru_o       = '0;
    valid_load   = '0;
    valid_o      = '0;
    dirty_load   = '0;
    dirty_o      = '0;
    tag_load     = '0;
    data_we_cpu  = '0;
    data_we_fill = '0;
    dimux_sel    = 1'b0;
    domux_sel    = '0;
    addrmux_sel  = 2'd0;
    set_ovr      = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;

    unique case (state)
      HIT_CHECK: begin
        if (req && hit_any) begin
          mem_resp  = 1'b1;
          domux_sel = hit_way;
          plru_load = 1'b1;
          plru_o    = plru_touch(plru_i, hit_way);
          if (mem_write) begin
            data_we_cpu = hit_oh;
            dirty_load  = hit_oh;
            dirty_o     = hit_oh;
          end
        end else if (req) begin
          victim_ld = 1'b1;
          state_nxt = dirty_i[victim_choice] ? WRITE_BACK : READ_BACK;
        end else if (flush_req) begin
          // A pending CPU request is checked first, so it always beats a flush.
          state_nxt = FLUSH_SCAN;
        end
      end

      WRITE_BACK: begin
        addrmux_sel = 2'd1;
        domux_sel   = victim;
        pmem_write  = 1'b1;
        if (pmem_resp) state_nxt = READ_BACK;
      end

      READ_BACK: begin
        // Array writes are held for the whole fill; the last one, on the
        // pmem_resp cycle, carries the complete line.
        pmem_read    = 1'b1;
        dimux_sel    = 1'b1;
        data_we_fill = victim_oh;
        tag_load     = victim_oh;
        valid_load   = victim_oh;
        valid_o      = victim_oh;
        dirty_load   = victim_oh;
        if (pmem_resp) state_nxt = HIT_CHECK;
      end

      FLUSH_SCAN: begin
        set_ovr = 1'b1;
        if (valid_i[flush_way] && dirty_i[flush_way]) begin
          state_nxt = FLUSH_WB;
        end else if (flush_last) begin
          state_nxt = FLUSH_DONE;
        end else begin
          flush_adv = 1'b1;
        end
      end

      FLUSH_WB: begin
        set_ovr     = 1'b1;
        domux_sel   = flush_way;
        addrmux_sel = 2'd1;
        pmem_write  = 1'b1;
        if (pmem_resp) begin
          dirty_load = flush_oh;
          if (flush_last) begin
            state_nxt = FLUSH_DONE;
          end else begin
            flush_adv = 1'b1;
            state_nxt = FLUSH_SCAN;
          end
        end
      end

      FLUSH_DONE: begin
        flush_done = 1'b1;
        flush_clr  = 1'b1;
        state_nxt  = HIT_CHECK;
      end

      default: state_nxt = HIT_CHECK;
    endcase
  end

endmodule
